// File: rtl/vga_scan_pkg.sv
// Shared VGA raster constants and types for the tank game's 640x480@60 Hz output.
// The game stage imports the same package for BLOCK_SIZE and the play-field size.
package vga_scan_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_FIELD_W = 550;
  localparam int VGA_FIELD_H = 450;
  localparam int BLOCK_SIZE  = 10;

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  // Inclusive range test on a raster counter.
  function automatic logic in_span(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_if.sv
// Raster bundle from the scan generator to the render/game stage.
interface vga_scan_if;
  import vga_scan_pkg::*;

  logic             pix_tick;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             video_on;
  logic             in_field;
  logic             hsync;
  logic             vsync;
  logic             frame_start;

  modport master (
    output pix_tick, x, y, video_on, in_field, hsync, vsync, frame_start
  );

  modport slave (
    input pix_tick, x, y, video_on, in_field, hsync, vsync, frame_start
  );

endinterface

// File: rtl/pix_tick_gen.sv
// Pixel-rate strobe: one clk high every CLK_DIV clks, first strobe CLK_DIV clks after reset.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic RST,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt_reg;
  logic          pix_tick_reg;
  logic          div_last;

  assign div_last = (div_cnt_reg == DW'(CLK_DIV - 1));

  // The strobe is registered so it stays low during reset even when CLK_DIV is 1.
  always_ff @(posedge clk) begin
    if (RST) begin
      div_cnt_reg  <= '0;
      pix_tick_reg <= 1'b0;
    end else begin
      div_cnt_reg  <= div_last ? '0 : div_cnt_reg + DW'(1);
      pix_tick_reg <= div_last;
    end
  end

  assign pix_tick = pix_tick_reg;

endmodule

// File: rtl/vga_scan.sv
// Free-running VGA raster generator: x/y counters, active/play-field decode,
// sync pulses delayed to match the render pipeline, and a start-of-vblank pulse.
module vga_scan
  import vga_scan_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int FIELD_W  = VGA_FIELD_W,
  parameter int FIELD_H  = VGA_FIELD_H,
  parameter int SYNC_DLY = 2
) (
  input logic        clk,
  input logic        RST,
  vga_scan_if.master vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  logic             pix_tick;
  logic [CNT_W-1:0] x_reg;
  logic [CNT_W-1:0] y_reg;
  logic             frame_start_reg;
  logic             x_last;
  logic             y_last;
  logic             video_on;
  sync_t            sync_raw;
  sync_t            sync_out;

  pix_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_tick_gen (
    .clk     (clk),
    .RST     (RST),
    .pix_tick(pix_tick)
  );

  assign x_last = (x_reg == CNT_W'(H_TOTAL - 1));
  assign y_last = (y_reg == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (RST) begin
      x_reg           <= '0;
      y_reg           <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      // Fires on the same edge that moves y into the first blanking line.
      frame_start_reg <= pix_tick && x_last && (y_reg == CNT_W'(V_ACTIVE - 1));
      if (pix_tick) begin
        if (x_last) begin
          x_reg <= '0;
          y_reg <= y_last ? '0 : y_reg + 1'b1;
        end else begin
          x_reg <= x_reg + 1'b1;
        end
      end
    end
  end

  assign video_on    = (int'(x_reg) < H_ACTIVE) && (int'(y_reg) < V_ACTIVE);
  assign sync_raw.hs = !in_span(x_reg, HS_FIRST, HS_LAST);
  assign sync_raw.vs = !in_span(y_reg, VS_FIRST, VS_LAST);

  generate
    if (SYNC_DLY == 0) begin : g_no_dly
      assign sync_out = sync_raw;
    end else begin : g_dly
      sync_t dly_reg [SYNC_DLY];

      // Reset flushes every stage to the idle (high) level so no stale pulse leaks out.
      always_ff @(posedge clk) begin
        if (RST) begin
          for (int i = 0; i < SYNC_DLY; i++) dly_reg[i] <= '1;
        end else if (pix_tick) begin
          dly_reg[0] <= sync_raw;
          for (int i = 1; i < SYNC_DLY; i++) dly_reg[i] <= dly_reg[i-1];
        end
      end

      assign sync_out = dly_reg[SYNC_DLY-1];
    end
  endgenerate

  assign vga.pix_tick    = pix_tick;
  assign vga.x           = x_reg;
  assign vga.y           = y_reg;
  assign vga.video_on    = video_on;
  assign vga.in_field    = video_on && (int'(x_reg) < FIELD_W) && (int'(y_reg) < FIELD_H);
  assign vga.hsync       = sync_out.hs;
  assign vga.vsync       = sync_out.vs;
  assign vga.frame_start = frame_start_reg;

endmodule
